// File: rtl/stopwatch_logger.sv
// Minutes/seconds stopwatch with up/down counting, lap capture and a
// circular operation log fed by accepted commands and countdown expiry.
module stopwatch_logger #(
    parameter int CLK_PER_TICK = 1,
    parameter int SEC_MAX      = 59,
    parameter int MIN_MAX      = 59,
    parameter int LOG_DEPTH    = 10,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd,
    input  logic              mode_down,
    input  logic [7:0]        preset_min,
    input  logic [7:0]        preset_sec,
    output logic [7:0]        sec,
    output logic [7:0]        min,
    output logic              running,
    output logic              expired,
    output logic [7:0]        lap_sec,
    output logic [7:0]        lap_min,
    output logic              log_we,
    output logic [ADDR_W-1:0] log_addr,
    output logic [18:0]       log_data,
    output logic              log_wrapped
);

    localparam int                PW          = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PW-1:0]     PRESC_LAST  = PW'(CLK_PER_TICK - 1);
    localparam logic [7:0]        SEC_LAST    = 8'(SEC_MAX);
    localparam logic [7:0]        MIN_LAST    = 8'(MIN_MAX);
    localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(LOG_DEPTH - 1);
    localparam logic [2:0]        CMD_START   = 3'b001;
    localparam logic [2:0]        CMD_STOP    = 3'b010;
    localparam logic [2:0]        CMD_LAP     = 3'b011;
    localparam logic [2:0]        CMD_RESET   = 3'b100;
    localparam logic [2:0]        CODE_EXPIRY = 3'b111;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    function automatic logic [7:0] sat8(input logic [7:0] v, input logic [7:0] lim);
        sat8 = (v > lim) ? lim : v;
    endfunction

    state_t              state_r, state_nxt_s;
    logic                mode_down_r, mode_nxt_s;
    logic [PW-1:0]       presc_r, presc_nxt_s;
    logic [7:0]          sec_r, min_r, sec_nxt_s, min_nxt_s;
    logic [7:0]          lap_sec_r, lap_min_r, lap_sec_nxt_s, lap_min_nxt_s;
    logic [7:0]          up_sec_s, up_min_s, down_sec_s, down_min_s;
    logic [ADDR_W-1:0]   wr_ptr_r, wr_ptr_nxt_s, log_addr_r, log_addr_nxt_s;
    logic [18:0]         log_data_r, log_data_nxt_s;
    logic                log_wrapped_r, log_wrapped_nxt_s;
    logic                log_we_r, expired_r, running_r;
    logic                start_acc_s, stop_acc_s, lap_acc_s, reset_acc_s, cmd_acc_s;
    logic                tick_s, adv_s, expire_s, log_event_s;
    logic [2:0]          log_code_s;

    // A down-mode START at 0:00 is refused so the countdown can never run from zero.
    assign start_acc_s = cmd_valid && (cmd == CMD_START) && (state_r == ST_STOPPED)
                         && !(mode_down_r && (min_r == 8'd0) && (sec_r == 8'd0));
    assign stop_acc_s  = cmd_valid && (cmd == CMD_STOP) && (state_r == ST_RUN);
    assign lap_acc_s   = cmd_valid && (cmd == CMD_LAP);
    assign reset_acc_s = cmd_valid && (cmd == CMD_RESET);
    assign cmd_acc_s   = start_acc_s || stop_acc_s || lap_acc_s || reset_acc_s;
    assign tick_s      = (state_r == ST_RUN) && (presc_r == PRESC_LAST);
    assign adv_s       = tick_s && !cmd_acc_s;
    assign expire_s    = adv_s && mode_down_r && (down_min_s == 8'd0) && (down_sec_s == 8'd0);
    assign log_event_s = cmd_acc_s || expire_s;
    assign log_code_s  = expire_s ? CODE_EXPIRY : cmd;

    // Candidate time values for one up or one down step.
    always_comb begin
        up_sec_s   = sec_r + 8'd1;
        up_min_s   = min_r;
        down_sec_s = sec_r - 8'd1;
        down_min_s = min_r;
        if (sec_r == SEC_LAST) begin
            up_sec_s = 8'd0;
            up_min_s = (min_r == MIN_LAST) ? 8'd0 : (min_r + 8'd1);
        end else begin
            up_min_s = min_r;
        end
        if (sec_r == 8'd0) begin
            down_sec_s = SEC_LAST;
            down_min_s = min_r - 8'd1;
        end else begin
            down_min_s = min_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_STOPPED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_STOPPED: begin
                if (start_acc_s) state_nxt_s = ST_RUN;
                else             state_nxt_s = ST_STOPPED;
            end
            ST_RUN: begin
                if (reset_acc_s || stop_acc_s) state_nxt_s = ST_STOPPED;
                else if (expire_s)             state_nxt_s = ST_EXPIRED;
                else                           state_nxt_s = ST_RUN;
            end
            ST_EXPIRED: begin
                if (reset_acc_s) state_nxt_s = ST_STOPPED;
                else             state_nxt_s = ST_EXPIRED;
            end
            default: state_nxt_s = ST_STOPPED;
        endcase
    end

    // Output/datapath next values: time, prescaler, lap capture and log write.
    always_comb begin
        sec_nxt_s         = sec_r;
        min_nxt_s         = min_r;
        mode_nxt_s        = mode_down_r;
        presc_nxt_s       = presc_r;
        lap_sec_nxt_s     = lap_sec_r;
        lap_min_nxt_s     = lap_min_r;
        wr_ptr_nxt_s      = wr_ptr_r;
        log_addr_nxt_s    = log_addr_r;
        log_data_nxt_s    = log_data_r;
        log_wrapped_nxt_s = log_wrapped_r;

        if (reset_acc_s) begin
            mode_nxt_s = mode_down;
            if (mode_down) begin
                min_nxt_s = sat8(preset_min, MIN_LAST);
                sec_nxt_s = sat8(preset_sec, SEC_LAST);
            end else begin
                min_nxt_s = 8'd0;
                sec_nxt_s = 8'd0;
            end
        end else if (adv_s) begin
            if (mode_down_r) begin
                min_nxt_s = down_min_s;
                sec_nxt_s = down_sec_s;
            end else begin
                min_nxt_s = up_min_s;
                sec_nxt_s = up_sec_s;
            end
        end else begin
            sec_nxt_s = sec_r;
        end

        // The prescaler keeps cycling in RUN even when a command swallows the tick.
        if (start_acc_s) begin
            presc_nxt_s = '0;
        end else if (state_r == ST_RUN) begin
            presc_nxt_s = (presc_r == PRESC_LAST) ? '0 : (presc_r + 1'b1);
        end else begin
            presc_nxt_s = presc_r;
        end

        if (lap_acc_s) begin
            lap_min_nxt_s = min_r;
            lap_sec_nxt_s = sec_r;
        end else begin
            lap_min_nxt_s = lap_min_r;
        end

        if (log_event_s) begin
            log_addr_nxt_s = wr_ptr_r;
            log_data_nxt_s = {log_code_s, min_r, sec_r};
            if (wr_ptr_r == ADDR_LAST) begin
                wr_ptr_nxt_s      = '0;
                log_wrapped_nxt_s = 1'b1;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r + 1'b1;
            end
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_down_r   <= 1'b0;
            presc_r       <= '0;
            sec_r         <= 8'd0;
            min_r         <= 8'd0;
            lap_sec_r     <= 8'd0;
            lap_min_r     <= 8'd0;
            wr_ptr_r      <= '0;
            log_addr_r    <= '0;
            log_data_r    <= 19'd0;
            log_wrapped_r <= 1'b0;
            log_we_r      <= 1'b0;
            expired_r     <= 1'b0;
            running_r     <= 1'b0;
        end else begin
            mode_down_r   <= mode_nxt_s;
            presc_r       <= presc_nxt_s;
            sec_r         <= sec_nxt_s;
            min_r         <= min_nxt_s;
            lap_sec_r     <= lap_sec_nxt_s;
            lap_min_r     <= lap_min_nxt_s;
            wr_ptr_r      <= wr_ptr_nxt_s;
            log_addr_r    <= log_addr_nxt_s;
            log_data_r    <= log_data_nxt_s;
            log_wrapped_r <= log_wrapped_nxt_s;
            log_we_r      <= log_event_s;
            expired_r     <= expire_s;
            running_r     <= (state_nxt_s == ST_RUN);
        end
    end

    assign sec         = sec_r;
    assign min         = min_r;
    assign running     = running_r;
    assign expired     = expired_r;
    assign lap_sec     = lap_sec_r;
    assign lap_min     = lap_min_r;
    assign log_we      = log_we_r;
    assign log_addr    = log_addr_r;
    assign log_data    = log_data_r;
    assign log_wrapped = log_wrapped_r;

endmodule

// File: tb/tb_stopwatch_logger.sv
// Scoreboard bench for stopwatch_logger: DUT a uses one clock per tick,
// DUT b uses four; expected log writes are queued and checked by monitors.
module tb_stopwatch_logger;

    localparam logic [2:0] C_NOP   = 3'b000;
    localparam logic [2:0] C_START = 3'b001;
    localparam logic [2:0] C_STOP  = 3'b010;
    localparam logic [2:0] C_LAP   = 3'b011;
    localparam logic [2:0] C_RESET = 3'b100;
    localparam logic [2:0] C_EXP   = 3'b111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_cmd_valid, a_mode, a_running, a_expired, a_log_we, a_log_wrapped;
    logic [2:0]  a_cmd;
    logic [7:0]  a_pmin, a_psec, a_sec, a_min, a_lap_sec, a_lap_min;
    logic [9:0]  a_log_addr;
    logic [18:0] a_log_data;

    logic        b_rst, b_cmd_valid, b_mode, b_running, b_expired, b_log_we, b_log_wrapped;
    logic [2:0]  b_cmd;
    logic [7:0]  b_pmin, b_psec, b_sec, b_min, b_lap_sec, b_lap_min;
    logic [9:0]  b_log_addr;
    logic [18:0] b_log_data;

    int n_tests = 0;
    int n_fail  = 0;
    int a_exp_cnt = 0;
    int a_ptr = 0;
    int b_ptr = 0;
    logic b_done = 1'b0;
    logic [28:0] a_q[$];
    logic [28:0] b_q[$];
    logic [28:0] a_e, b_e;

    stopwatch_logger u_a (
        .clk(clk), .rst(a_rst), .cmd_valid(a_cmd_valid), .cmd(a_cmd), .mode_down(a_mode),
        .preset_min(a_pmin), .preset_sec(a_psec), .sec(a_sec), .min(a_min),
        .running(a_running), .expired(a_expired), .lap_sec(a_lap_sec), .lap_min(a_lap_min),
        .log_we(a_log_we), .log_addr(a_log_addr), .log_data(a_log_data), .log_wrapped(a_log_wrapped)
    );

    stopwatch_logger #(.CLK_PER_TICK(4)) u_b (
        .clk(clk), .rst(b_rst), .cmd_valid(b_cmd_valid), .cmd(b_cmd), .mode_down(b_mode),
        .preset_min(b_pmin), .preset_sec(b_psec), .sec(b_sec), .min(b_min),
        .running(b_running), .expired(b_expired), .lap_sec(b_lap_sec), .lap_min(b_lap_min),
        .log_we(b_log_we), .log_addr(b_log_addr), .log_data(b_log_data), .log_wrapped(b_log_wrapped)
    );

    function automatic void chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void push_a(input logic [2:0] c, input int m, input int s);
        a_q.push_back({10'(a_ptr), c, 8'(m), 8'(s)});
        a_ptr = (a_ptr == 9) ? 0 : a_ptr + 1;
    endfunction

    function automatic void push_b(input logic [2:0] c, input int m, input int s);
        b_q.push_back({10'(b_ptr), c, 8'(m), 8'(s)});
        b_ptr = (b_ptr == 9) ? 0 : b_ptr + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_issue(input logic [2:0] c);
        a_cmd_valid = 1'b1;
        a_cmd = c;
        step();
        a_cmd_valid = 1'b0;
        a_cmd = C_NOP;
    endtask

    task automatic b_issue(input logic [2:0] c);
        b_cmd_valid = 1'b1;
        b_cmd = c;
        step();
        b_cmd_valid = 1'b0;
        b_cmd = C_NOP;
    endtask

    task automatic a_all_zero(input string tag);
        chk({tag, "_sec"}, int'(a_sec), 0);
        chk({tag, "_min"}, int'(a_min), 0);
        chk({tag, "_running"}, int'(a_running), 0);
        chk({tag, "_expired"}, int'(a_expired), 0);
        chk({tag, "_lap"}, int'({a_lap_min, a_lap_sec}), 0);
        chk({tag, "_log_we"}, int'(a_log_we), 0);
        chk({tag, "_log_addr"}, int'(a_log_addr), 0);
        chk({tag, "_log_data"}, int'(a_log_data), 0);
        chk({tag, "_log_wrapped"}, int'(a_log_wrapped), 0);
    endtask

    // Log monitor for DUT a, plus expiry pulse counter.
    always @(negedge clk) begin
        if (a_expired) a_exp_cnt++;
        if (a_log_we) begin
            if (a_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_log_unexpected: got write addr %0d data %h, expected no write",
                         a_log_addr, a_log_data);
            end else begin
                a_e = a_q.pop_front();
                chk("a_log_addr", int'(a_log_addr), int'(a_e[28:19]));
                chk("a_log_data", int'(a_log_data), int'(a_e[18:0]));
            end
        end
    end

    // Log monitor for DUT b.
    always @(negedge clk) begin
        if (b_log_we) begin
            if (b_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_log_unexpected: got write addr %0d data %h, expected no write",
                         b_log_addr, b_log_data);
            end else begin
                b_e = b_q.pop_front();
                chk("b_log_addr", int'(b_log_addr), int'(b_e[28:19]));
                chk("b_log_data", int'(b_log_data), int'(b_e[18:0]));
            end
        end
    end

    // DUT b: four clocks per tick; STOP nine clocks after START leaves 0:02.
    initial begin
        b_rst = 1'b1; b_cmd_valid = 1'b0; b_cmd = C_NOP; b_mode = 1'b0; b_pmin = 8'd0; b_psec = 8'd0;
        step(); step();
        b_rst = 1'b0;
        push_b(C_START, 0, 0);
        b_issue(C_START);
        chk("b_running_after_start", int'(b_running), 1);
        repeat (3) step();
        chk("b_no_tick_yet", int'(b_sec), 0);
        repeat (5) step();
        chk("b_two_ticks", int'(b_sec), 2);
        push_b(C_STOP, 0, 2);
        b_issue(C_STOP);
        chk("b_stop_sec", int'(b_sec), 2);
        chk("b_stop_running", int'(b_running), 0);
        b_issue(C_STOP);
        repeat (6) step();
        chk("b_frozen_sec", int'(b_sec), 2);
        b_done = 1'b1;
    end

    // DUT a: main directed sequence.
    initial begin
        a_rst = 1'b1; a_cmd_valid = 1'b0; a_cmd = C_NOP; a_mode = 1'b0; a_pmin = 8'd0; a_psec = 8'd0;
        step(); step();
        a_rst = 1'b0;
        a_all_zero("reset");

        // Undefined code, NOP and a STOP while stopped: none may log.
        a_issue(3'b101);
        a_issue(C_NOP);
        a_issue(C_STOP);

        push_a(C_RESET, 0, 0);
        a_issue(C_RESET);
        push_a(C_START, 0, 0);
        a_issue(C_START);
        chk("up_running", int'(a_running), 1);
        repeat (60) step();
        chk("up_60_min", int'(a_min), 1);
        chk("up_60_sec", int'(a_sec), 0);

        // STOP lands on a tick cycle, so time stays at 1:00.
        push_a(C_STOP, 1, 0);
        a_issue(C_STOP);
        chk("stop_tick_min", int'(a_min), 1);
        chk("stop_tick_sec", int'(a_sec), 0);
        chk("stop_running", int'(a_running), 0);
        a_issue(C_STOP);
        step();

        // Countdown from 0:03.
        a_mode = 1'b1; a_pmin = 8'd0; a_psec = 8'd3;
        push_a(C_RESET, 1, 0);
        a_issue(C_RESET);
        chk("down_preset_sec", int'(a_sec), 3);
        chk("down_preset_min", int'(a_min), 0);
        push_a(C_START, 0, 3);
        a_issue(C_START);
        push_a(C_EXP, 0, 1);
        step(); step();
        chk("down_not_yet_expired", int'(a_expired), 0);
        chk("down_sec_1", int'(a_sec), 1);
        step();
        chk("down_expired", int'(a_expired), 1);
        chk("down_zero", int'({a_min, a_sec}), 0);
        chk("down_running_off", int'(a_running), 0);
        step();
        chk("down_expired_pulse", int'(a_expired), 0);
        a_issue(C_START);
        chk("start_after_expiry", int'(a_running), 0);
        step();
        chk("expired_count", a_exp_cnt, 1);

        // Preset above the limits saturates to 59:59.
        a_pmin = 8'd200; a_psec = 8'd200;
        push_a(C_RESET, 0, 0);
        a_issue(C_RESET);
        chk("sat_min", int'(a_min), 59);
        chk("sat_sec", int'(a_sec), 59);

        // Up mode wrap at 59:59.
        a_mode = 1'b0;
        push_a(C_RESET, 59, 59);
        a_issue(C_RESET);
        chk("up_reset_zero", int'({a_min, a_sec}), 0);
        push_a(C_START, 0, 0);
        a_issue(C_START);
        repeat (3599) step();
        chk("wrap_pre_min", int'(a_min), 59);
        chk("wrap_pre_sec", int'(a_sec), 59);
        step();
        chk("wrap_zero", int'({a_min, a_sec}), 0);
        chk("wrap_running", int'(a_running), 1);
        chk("not_wrapped_yet", int'(a_log_wrapped), 0);

        a_rst = 1'b1;
        step(); step();
        a_rst = 1'b0;
        a_ptr = 0;
        chk("queue_drained_1", a_q.size(), 0);

        // START then 11 LAPs separated by one tick each: LAP i captures 0:i.
        push_a(C_START, 0, 0);
        a_issue(C_START);
        for (int i = 0; i < 11; i++) begin
            push_a(C_LAP, 0, i);
            a_issue(C_LAP);
            if (i == 8) chk("wrapped_set", int'(a_log_wrapped), 1);
            if (i == 9) chk("wrap_addr", int'(a_log_addr), 0);
            step();
        end
        chk("lap_min", int'(a_lap_min), 0);
        chk("lap_sec", int'(a_lap_sec), 10);
        chk("wrapped_sticky", int'(a_log_wrapped), 1);

        // rst together with an accepted LAP: no write, everything cleared.
        a_cmd_valid = 1'b1; a_cmd = C_LAP; a_rst = 1'b1;
        step();
        a_cmd_valid = 1'b0; a_cmd = C_NOP; a_rst = 1'b0;
        a_ptr = 0;
        a_all_zero("rst_pending");
        step();
        chk("queue_drained_2", a_q.size(), 0);

        for (int i = 0; i < 1000 && !b_done; i++) step();
        chk("b_done", int'(b_done), 1);
        chk("b_queue_drained", b_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
